fft_blk_seq_ctrl: RTL and testbench

//  Frame sequencer for the 16-lane parallel I/Q FFT pipeline. Accepts one
//  16-sample block per valid cycle and counts blocks within a frame. Runs a
//  {valid,sof,eof} tag chain in lock-step with the free-running 16-lane

---
 rtl/fft_blk_seq_ctrl_pkg.sv | 12 +
 rtl/fft_blk_seq_ctrl_if.sv | 18 +
 rtl/fft_blk_seq_ctrl_tag_pipe.sv | 20 ++
 rtl/fft_blk_seq_ctrl.sv | 77 +++++++
 tb/tb_fft_blk_seq_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/fft_blk_seq_ctrl_pkg.sv
// fft_pkg: shared types for the FFT block sequencer and its tag chain
package fft_pkg;
  typedef struct packed {
    logic valid;
    logic sof;
    logic eof;
  } fft_tag_t;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_DRAIN} seq_state_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fft_blk_seq_ctrl_if.sv
// fft_blk_seq_ctrl_if: block handshake, stage enables and frame markers of the sequencer
interface fft_blk_seq_ctrl_if #(
  parameter int NUM_STAGES = 9,
  parameter int BLK_W = 5
);
  logic in_valid, in_sof, cfg_clear, in_ready;
  logic [BLK_W-1:0] in_blk_idx;
  logic [NUM_STAGES-1:0] stage_en;
  logic out_valid, out_sof, out_eof, busy, err_sof, err_nosof;
  modport master(
    output in_valid, in_sof, cfg_clear,
    input in_ready, in_blk_idx, stage_en, out_valid, out_sof, out_eof, busy, err_sof, err_nosof
  );
  modport slave(
    input in_valid, in_sof, cfg_clear,
    output in_ready, in_blk_idx, stage_en, out_valid, out_sof, out_eof, busy, err_sof, err_nosof
  );
endinterface

// File: rtl/fft_blk_seq_ctrl_tag_pipe.sv
// fft_tag_pipe: free-running {valid,sof,eof} shift chain mirroring the datapath stages
module fft_tag_pipe
  import fft_pkg::*;
#(
  parameter int NUM_STAGES = 9
) (
  input  logic                  clk,
  input  logic                  clr,
  input  fft_tag_t              d,
  output logic [NUM_STAGES-1:0] vld,
  output fft_tag_t              q
);
  fft_tag_t [NUM_STAGES-1:0] tag;
  // the truncating cast drops the oldest tag and shifts d into stage 0
  always_ff @(posedge clk) tag <= clr ? '0 : (NUM_STAGES*3)'({tag, d});
  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_en
    assign vld[s] = tag[s].valid;
  end
  assign q = tag[NUM_STAGES-1];
endmodule

// File: rtl/fft_blk_seq_ctrl.sv
// fft_blk_seq_ctrl: frame sequencer for the 16-lane FFT pipeline, counts blocks and flags framing errors
// Error pulses are registered, so they appear the cycle after the offending block.
module fft_blk_seq_ctrl
  import fft_pkg::*;
#(
  parameter int NUM_IN_OUT = 16,
  parameter int FFT_POINTS = 512,
  parameter int NUM_STAGES = 9
) (
  input logic clk,
  input logic rstn,
  fft_blk_seq_ctrl_if.slave bus
);
  localparam int BLKS = FFT_POINTS / NUM_IN_OUT;
  localparam int BLK_W = cnt_w(BLKS);
  localparam int DRN_W = cnt_w(NUM_STAGES);
  localparam logic ONE = BLKS == 1;
  localparam logic [BLK_W-1:0] LAST = BLK_W'(BLKS - 1);
  localparam logic [DRN_W-1:0] DLAST = DRN_W'(NUM_STAGES - 1);
  seq_state_t state, state_d;
  logic [BLK_W-1:0] blk_cnt, cnt_d;
  logic [DRN_W-1:0] drain_cnt, drain_d;
  logic clr, acc, last, err_sof_q, err_nosof_q;
  fft_tag_t tag_d, tag_q;
  assign clr = !rstn || bus.cfg_clear;
  assign acc = bus.in_valid && !bus.cfg_clear;
  assign last = blk_cnt == LAST;
  always_comb begin
    state_d = state;
    cnt_d = blk_cnt;
    drain_d = drain_cnt == DLAST ? drain_cnt : drain_cnt + 1'b1;
    tag_d = '0;
    if (acc && bus.in_sof) begin
      state_d = ONE ? SEQ_DRAIN : SEQ_RUN;
      cnt_d = ONE ? '0 : BLK_W'(1);
      drain_d = '0;
      tag_d = '{valid: 1'b1, sof: 1'b1, eof: ONE};
    end else if (acc && state == SEQ_RUN) begin
      state_d = last ? SEQ_DRAIN : SEQ_RUN;
      cnt_d = last ? '0 : blk_cnt + 1'b1;
      drain_d = '0;
      tag_d = '{valid: 1'b1, sof: 1'b0, eof: last};
    end else if (!acc && state == SEQ_DRAIN && drain_cnt == DLAST) begin
      state_d = SEQ_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= SEQ_IDLE;
      blk_cnt <= '0;
      drain_cnt <= '0;
      err_sof_q <= 1'b0;
      err_nosof_q <= 1'b0;
    end else begin
      state <= state_d;
      blk_cnt <= cnt_d;
      drain_cnt <= drain_d;
      err_sof_q <= acc && bus.in_sof && state == SEQ_RUN;
      err_nosof_q <= acc && !bus.in_sof && state != SEQ_RUN;
    end
  end
  fft_tag_pipe #(.NUM_STAGES(NUM_STAGES)) u_pipe (
    .clk(clk),
    .clr(clr),
    .d(tag_d),
    .vld(bus.stage_en),
    .q(tag_q)
  );
  assign bus.in_ready = !bus.cfg_clear;
  assign bus.in_blk_idx = state == SEQ_RUN ? blk_cnt : '0;
  assign bus.out_valid = tag_q.valid;
  assign bus.out_sof = tag_q.sof;
  assign bus.out_eof = tag_q.eof;
  assign bus.busy = state != SEQ_IDLE || |bus.stage_en;
  assign bus.err_sof = err_sof_q;
  assign bus.err_nosof = err_nosof_q;
endmodule

// File: tb/tb_fft_blk_seq_ctrl.sv
// tb_fft_blk_seq_ctrl: vector table, directed frame scenarios and random traffic against a frame-level model
module tb_fft_blk_seq_ctrl;
  import fft_pkg::*;
  localparam int NS = 9;
  localparam int BLKS = 32;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  fft_blk_seq_ctrl_if #(.NUM_STAGES(NS), .BLK_W(5)) bus ();
  fft_blk_seq_ctrl #(.NUM_IN_OUT(16), .FFT_POINTS(512), .NUM_STAGES(NS)) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus.slave)
  );
  int n_cmp = 0;
  int n_bad = 0;
  int m_state, m_cnt, m_drain;
  bit m_esof, m_enosof;
  fft_tag_t m_pipe[$];
  logic smp_ready, smp_valid, smp_sof, smp_eof, smp_busy, smp_esof, smp_enosof;
  logic [NS-1:0] smp_en;
  int smp_idx;
  typedef struct {
    bit r, v, s, c;
    bit ready;
    int idx;
    bit busy, enosof, esof;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state = 0;
    m_cnt = 0;
    m_drain = 0;
    m_esof = 0;
    m_enosof = 0;
    m_pipe.delete();
    for (int i = 0; i < NS; i++) m_pipe.push_back('0);
  endtask

  // frame-level reference: 0 idle, 1 in frame, 2 draining after eof
  task automatic m_step(input bit v, input bit s, input bit c, input bit r);
    fft_tag_t nt;
    bit lst;
    nt = '0;
    if (!r || c) begin
      m_reset();
      return;
    end
    m_esof = 0;
    m_enosof = 0;
    if (v && s) begin
      m_esof = m_state == 1;
      nt = '{valid: 1'b1, sof: 1'b1, eof: 1'(BLKS == 1)};
      m_cnt = BLKS == 1 ? 0 : 1;
      m_state = BLKS == 1 ? 2 : 1;
      m_drain = 0;
    end else if (v && m_state == 1) begin
      lst = m_cnt == BLKS - 1;
      nt = '{valid: 1'b1, sof: 1'b0, eof: lst};
      m_cnt = lst ? 0 : m_cnt + 1;
      if (lst) begin
        m_state = 2;
        m_drain = 0;
      end
    end else begin
      m_enosof = v;
      if (m_state == 2) begin
        if (!v && m_drain >= NS - 1) m_state = 0;
        m_drain++;
      end
    end
    m_pipe.push_front(nt);
    void'(m_pipe.pop_back());
  endtask

  task automatic cycle(input bit v, input bit s, input bit c, input bit r);
    logic [NS-1:0] e_en;
    fft_tag_t o;
    rstn = r;
    bus.in_valid = v;
    bus.in_sof = s;
    bus.cfg_clear = c;
    @(negedge clk);
    for (int i = 0; i < NS; i++) e_en[i] = m_pipe[i].valid;
    o = m_pipe[NS-1];
    chk("in_ready", 32'(bus.in_ready), 32'(!c));
    chk("in_blk_idx", 32'(bus.in_blk_idx), 32'(m_state == 1 ? m_cnt : 0));
    chk("stage_en", 32'(bus.stage_en), 32'(e_en));
    chk("out_valid", 32'(bus.out_valid), 32'(o.valid));
    chk("out_sof", 32'(bus.out_sof), 32'(o.sof));
    chk("out_eof", 32'(bus.out_eof), 32'(o.eof));
    chk("busy", 32'(bus.busy), 32'(m_state != 0 || |e_en));
    chk("err_sof", 32'(bus.err_sof), 32'(m_esof));
    chk("err_nosof", 32'(bus.err_nosof), 32'(m_enosof));
    smp_ready = bus.in_ready;
    smp_idx = int'(bus.in_blk_idx);
    smp_en = bus.stage_en;
    smp_valid = bus.out_valid;
    smp_sof = bus.out_sof;
    smp_eof = bus.out_eof;
    smp_busy = bus.busy;
    smp_esof = bus.err_sof;
    smp_enosof = bus.err_nosof;
    @(posedge clk);
    m_step(v, s, c, r);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 1);
  endtask

  initial begin
    int nv, ne;
    tbl[0] = '{r: 0, v: 1, s: 0, c: 0, ready: 1, idx: 0, busy: 0, enosof: 0, esof: 0};
    tbl[1] = '{r: 1, v: 1, s: 0, c: 0, ready: 1, idx: 0, busy: 0, enosof: 0, esof: 0};
    tbl[2] = '{r: 1, v: 0, s: 0, c: 0, ready: 1, idx: 0, busy: 0, enosof: 1, esof: 0};
    tbl[3] = '{r: 1, v: 1, s: 1, c: 0, ready: 1, idx: 0, busy: 0, enosof: 0, esof: 0};
    tbl[4] = '{r: 1, v: 1, s: 0, c: 0, ready: 1, idx: 1, busy: 1, enosof: 0, esof: 0};
    tbl[5] = '{r: 1, v: 1, s: 1, c: 0, ready: 1, idx: 2, busy: 1, enosof: 0, esof: 0};
    tbl[6] = '{r: 1, v: 0, s: 0, c: 0, ready: 1, idx: 1, busy: 1, enosof: 0, esof: 1};
    tbl[7] = '{r: 1, v: 1, s: 0, c: 1, ready: 0, idx: 1, busy: 1, enosof: 0, esof: 0};
    tbl[8] = '{r: 1, v: 0, s: 0, c: 0, ready: 1, idx: 0, busy: 0, enosof: 0, esof: 0};
    bus.in_valid = 1'b1;
    bus.in_sof = 1'b0;
    bus.cfg_clear = 1'b0;
    @(posedge clk);
    m_reset();
    #1;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("rst_stage_en", 32'(smp_en), 32'd0);
    chk("rst_ready", 32'(smp_ready), 32'd1);
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].v, tbl[i].s, tbl[i].c, tbl[i].r);
      chk("tbl_ready", 32'(smp_ready), 32'(tbl[i].ready));
      chk("tbl_idx", 32'(smp_idx), 32'(tbl[i].idx));
      chk("tbl_busy", 32'(smp_busy), 32'(tbl[i].busy));
      chk("tbl_err_nosof", 32'(smp_enosof), 32'(tbl[i].enosof));
      chk("tbl_err_sof", 32'(smp_esof), 32'(tbl[i].esof));
    end
    idle(3);
    nv = 0;
    for (int k = 0; k < 46; k++) begin
      cycle(k < 32, k == 0, 0, 1);
      nv += int'(smp_valid);
      if (k == 8) chk("full_sof8", 32'(smp_sof), 32'd0);
      if (k == 9) chk("full_sof9", 32'(smp_sof), 32'd1);
      if (k == 40) chk("full_eof40", 32'(smp_eof), 32'd1);
      if (k == 40) chk("full_busy40", 32'(smp_busy), 32'd1);
      if (k == 41) chk("full_busy41", 32'(smp_busy), 32'd0);
    end
    chk("full_nvalid", 32'(nv), 32'd32);
    ne = 0;
    for (int k = 0; k < 76; k++) begin
      cycle(k < 64, k == 0 || k == 32, 0, 1);
      ne += int'(smp_esof) + int'(smp_enosof);
      if (k == 40) chk("b2b_eof40", 32'(smp_eof), 32'd1);
      if (k == 41) chk("b2b_sof41", 32'(smp_sof), 32'd1);
    end
    chk("b2b_errs", 32'(ne), 32'd0);
    for (int k = 0; k < 76; k++) begin
      cycle(k % 2 == 0 && k < 64, k == 0, 0, 1);
      if (k % 2 == 0 && k < 64) chk("gap_idx", 32'(smp_idx), 32'(k / 2));
      chk("gap_valid", 32'(smp_valid), 32'(k >= 9 && (k - 9) % 2 == 0 && k - 9 < 64));
    end
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    chk("nosof_pulse", 32'(smp_enosof), 32'd1);
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      cycle(0, 0, 0, 1);
      nv += int'(smp_valid);
    end
    chk("nosof_novalid", 32'(nv), 32'd0);
    for (int k = 0; k < 56; k++) begin
      cycle(k < 42, k == 0 || k == 10, 0, 1);
      if (k == 11) chk("midsof_pulse", 32'(smp_esof), 32'd1);
      if (k == 40) chk("midsof_eof40", 32'(smp_eof), 32'd0);
      if (k == 50) chk("midsof_eof50", 32'(smp_eof), 32'd1);
    end
    for (int k = 0; k < 16; k++) begin
      cycle(k <= 5, k == 0, k == 5, 1);
      if (k == 5) chk("clr_en5", 32'(smp_en), 32'h1f);
      if (k == 6) chk("clr_en6", 32'(smp_en), 32'd0);
      if (k == 6) chk("clr_busy6", 32'(smp_busy), 32'd0);
      if (k > 5) chk("clr_novalid", 32'(smp_valid), 32'd0);
    end
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 199) == 0, $urandom_range(0, 499) != 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
